// File: rtl/pid_mc_pkg.sv
// Shared definitions for the multi-channel PID core.
//   state_t        : controller FSM states
//   ADDR_*         : parameter-write address map
//   out_min_of/out_max_of : most negative / most positive value of a w-bit signed word
package pid_mc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COMPUTE   = 2'd1,
    ST_SEND      = 2'd2,
    ST_WRITEBACK = 2'd3
  } state_t;

  localparam logic [2:0] ADDR_SP  = 3'd0;
  localparam logic [2:0] ADDR_P   = 3'd1;
  localparam logic [2:0] ADDR_I   = 3'd2;
  localparam logic [2:0] ADDR_D   = 3'd3;
  localparam logic [2:0] ADDR_MIN = 3'd4;
  localparam logic [2:0] ADDR_MAX = 3'd5;
  localparam logic [2:0] ADDR_POL = 3'd6;

  function automatic longint out_min_of(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

  function automatic longint out_max_of(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

endpackage

// File: rtl/pid_mac.sv
// Combinational PID arithmetic for one sample of one channel.
// Ports:
//   data, setpoint, polarity : sample and its reference; e is the signed error
//   p, i, d                  : loop coefficients
//   lim_min, lim_max         : clamp limits, already extended and shifted (W_OUT+1 bits)
//   u_prev, e1, e2           : channel history (last output, last two errors)
//   e                        : error of this sample (written back as the new e1)
//   u                        : clamped output (also the new integrator state)
module pid_mac
  import pid_mc_pkg::*;
#(
  parameter int W_IN  = 18,
  parameter int W_OUT = 32,
  parameter int W_EP  = 16
) (
  input  logic signed [W_IN-1:0]  data,
  input  logic signed [W_EP-1:0]  setpoint,
  input  logic                    polarity,
  input  logic signed [W_EP-1:0]  p,
  input  logic signed [W_EP-1:0]  i,
  input  logic signed [W_EP-1:0]  d,
  input  logic signed [W_OUT:0]   lim_min,
  input  logic signed [W_OUT:0]   lim_max,
  input  logic signed [W_OUT-1:0] u_prev,
  input  logic signed [W_IN:0]    e1,
  input  logic signed [W_IN:0]    e2,
  output logic signed [W_IN:0]    e,
  output logic signed [W_OUT-1:0] u
);
  localparam int WE = W_IN + 1;
  localparam int WK = W_EP + 2;
  // three products of WE x WK bits plus two bits of sum growth
  localparam int WD = WE + WK + 2;

  logic signed [WK-1:0]  k1, k2, k3;
  logic signed [WD-1:0]  delta;
  logic signed [W_OUT:0] s;

  // An inverted window (lo > hi) resolves to the upper limit.
  function automatic logic signed [W_OUT:0] clamp(input logic signed [W_OUT:0] x,
                                                  input logic signed [W_OUT:0] lo,
                                                  input logic signed [W_OUT:0] hi);
    if (lo > hi)     return hi;
    else if (x > hi) return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction

  always_comb begin
    e     = polarity ? WE'(data) - WE'(setpoint) : WE'(setpoint) - WE'(data);
    k1    = WK'(p) + WK'(i) + WK'(d);
    k2    = -WK'(p) - (WK'(d) <<< 1);
    k3    = WK'(d);
    delta = WD'(k1) * WD'(e) + WD'(k2) * WD'(e1) + WD'(k3) * WD'(e2);
    // the running sum wraps at W_OUT+1 bits before clamping
    s     = (W_OUT+1)'(u_prev) + (W_OUT+1)'(delta);
    u     = W_OUT'(clamp(s, lim_min, lim_max));
  end

endmodule

// File: rtl/pid_core_mc.sv
// Time-multiplexed PID controller: N_CH independent loops sharing one pid_mac.
// Ports:
//   clk_in, reset_n_in             : clock, synchronous active-low reset
//   data_in/_chan_in/_valid_in     : channel-tagged input sample
//   data_ready_out                 : high when a sample can be accepted (IDLE, out of reset)
//   param_wr_in/_chan_in/_addr_in/_data_in : shadow parameter write
//   update_en_in, update_in        : commit all shadow parameters to active
//   clear_in, clear_chan_in        : zero one channel's history
//   data_out/_chan_out/_valid_out  : clamped PID sum, its channel, one-cycle strobe
module pid_core_mc
  import pid_mc_pkg::*;
#(
  parameter int N_CH         = 8,
  parameter int W_CH         = 3,
  parameter int W_IN         = 18,
  parameter int W_OUT        = 32,
  parameter int W_EP         = 16,
  parameter int LIM_SHIFT    = 16,
  parameter int COMP_LATENCY = 2
) (
  input  logic                    clk_in,
  input  logic                    reset_n_in,
  input  logic signed [W_IN-1:0]  data_in,
  input  logic [W_CH-1:0]         data_chan_in,
  input  logic                    data_valid_in,
  output logic                    data_ready_out,
  input  logic                    param_wr_in,
  input  logic [W_CH-1:0]         param_chan_in,
  input  logic [2:0]              param_addr_in,
  input  logic signed [W_EP-1:0]  param_data_in,
  input  logic                    update_en_in,
  input  logic                    update_in,
  input  logic                    clear_in,
  input  logic [W_CH-1:0]         clear_chan_in,
  output logic signed [W_OUT-1:0] data_out,
  output logic [W_CH-1:0]         data_chan_out,
  output logic                    data_valid_out
);
  localparam logic signed [W_OUT:0] LIM_LO = (W_OUT+1)'(out_min_of(W_OUT));
  localparam logic signed [W_OUT:0] LIM_HI = (W_OUT+1)'(out_max_of(W_OUT));

  // Limits are stored already extended and shifted, so the reset value can
  // cover the full W_OUT range.
  function automatic logic signed [W_OUT:0] lim_ext(input logic signed [W_EP-1:0] v);
    return (W_OUT+1)'(v) <<< LIM_SHIFT;
  endfunction

  state_t state, state_nxt;
  logic [7:0] cnt;
  logic accept, chan_ok, wb_kill;

  logic signed [W_EP-1:0] sp_sh [N_CH], p_sh [N_CH], i_sh [N_CH], d_sh [N_CH];
  logic signed [W_EP-1:0] sp_act[N_CH], p_act[N_CH], i_act[N_CH], d_act[N_CH];
  logic signed [W_OUT:0]  min_sh[N_CH], max_sh[N_CH], min_act[N_CH], max_act[N_CH];
  logic                   pol_sh[N_CH], pol_act[N_CH];

  logic signed [W_OUT-1:0] u_hist [N_CH];
  logic signed [W_IN:0]    e1_hist[N_CH], e2_hist[N_CH];

  logic signed [W_IN-1:0]  data_p0;
  logic [W_CH-1:0]         chan_p0;
  logic signed [W_EP-1:0]  sp_p0, p_p0, i_p0, d_p0;
  logic                    pol_p0, kill_p0;
  logic signed [W_OUT:0]   min_p0, max_p0;
  logic signed [W_OUT-1:0] u_p0;
  logic signed [W_IN:0]    e1_p0, e2_p0;

  logic signed [W_IN:0]    e_mac;
  logic signed [W_OUT-1:0] u_mac;

  assign chan_ok        = int'(data_chan_in) < N_CH;
  assign data_ready_out = (state == ST_IDLE) && reset_n_in;
  assign accept         = data_ready_out && data_valid_in;
  // a clear aimed at the in-flight channel, now or earlier, blocks its writeback
  assign wb_kill        = kill_p0 || (clear_in && clear_chan_in == chan_p0);

  always_comb begin
    state_nxt      = state;
    data_valid_out = 1'b0;
    case (state)
      ST_IDLE:      if (accept && chan_ok) state_nxt = ST_COMPUTE;
      ST_COMPUTE:   if (cnt == 8'(COMP_LATENCY - 1)) state_nxt = ST_SEND;
      ST_SEND: begin
        data_valid_out = 1'b1;
        state_nxt      = ST_WRITEBACK;
      end
      ST_WRITEBACK: state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      kill_p0       <= 1'b0;
      data_out      <= '0;
      data_chan_out <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == ST_COMPUTE && state_nxt == ST_COMPUTE) ? cnt + 8'd1 : 8'd0;
      if (accept)
        kill_p0 <= clear_in && clear_chan_in == data_chan_in;
      else if (state != ST_IDLE && clear_in && clear_chan_in == chan_p0)
        kill_p0 <= 1'b1;
      if (state == ST_COMPUTE && state_nxt == ST_SEND) begin
        data_out      <= u_mac;
        data_chan_out <= chan_p0;
      end
    end
  end

  // ---- stage p0: sample, channel params and history captured at acceptance ----
  always_ff @(posedge clk_in) begin
    if (accept && chan_ok) begin
      data_p0 <= data_in;
      chan_p0 <= data_chan_in;
      sp_p0   <= sp_act[data_chan_in];
      p_p0    <= p_act[data_chan_in];
      i_p0    <= i_act[data_chan_in];
      d_p0    <= d_act[data_chan_in];
      pol_p0  <= pol_act[data_chan_in];
      min_p0  <= min_act[data_chan_in];
      max_p0  <= max_act[data_chan_in];
      u_p0    <= u_hist[data_chan_in];
      e1_p0   <= e1_hist[data_chan_in];
      e2_p0   <= e2_hist[data_chan_in];
    end
  end

  pid_mac #(.W_IN(W_IN), .W_OUT(W_OUT), .W_EP(W_EP)) u_mac_i (
    .data(data_p0), .setpoint(sp_p0), .polarity(pol_p0),
    .p(p_p0), .i(i_p0), .d(d_p0),
    .lim_min(min_p0), .lim_max(max_p0),
    .u_prev(u_p0), .e1(e1_p0), .e2(e2_p0),
    .e(e_mac), .u(u_mac)
  );

  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      for (int c = 0; c < N_CH; c++) begin
        sp_sh[c]  <= '0;  p_sh[c]  <= '0;  i_sh[c]  <= '0;  d_sh[c]  <= '0;
        sp_act[c] <= '0;  p_act[c] <= '0;  i_act[c] <= '0;  d_act[c] <= '0;
        min_sh[c] <= LIM_LO;  max_sh[c]  <= LIM_HI;
        min_act[c] <= LIM_LO; max_act[c] <= LIM_HI;
        pol_sh[c] <= 1'b0;    pol_act[c] <= 1'b0;
      end
    end else begin
      // nonblocking copy: a same-cycle write lands only in the shadow
      if (update_in && update_en_in) begin
        for (int c = 0; c < N_CH; c++) begin
          sp_act[c]  <= sp_sh[c];  p_act[c]   <= p_sh[c];
          i_act[c]   <= i_sh[c];   d_act[c]   <= d_sh[c];
          min_act[c] <= min_sh[c]; max_act[c] <= max_sh[c];
          pol_act[c] <= pol_sh[c];
        end
      end
      if (param_wr_in && int'(param_chan_in) < N_CH) begin
        case (param_addr_in)
          ADDR_SP:  sp_sh[param_chan_in]  <= param_data_in;
          ADDR_P:   p_sh[param_chan_in]   <= param_data_in;
          ADDR_I:   i_sh[param_chan_in]   <= param_data_in;
          ADDR_D:   d_sh[param_chan_in]   <= param_data_in;
          ADDR_MIN: min_sh[param_chan_in] <= lim_ext(param_data_in);
          ADDR_MAX: max_sh[param_chan_in] <= lim_ext(param_data_in);
          ADDR_POL: pol_sh[param_chan_in] <= param_data_in[0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      for (int c = 0; c < N_CH; c++) begin
        u_hist[c]  <= '0;
        e1_hist[c] <= '0;
        e2_hist[c] <= '0;
      end
    end else begin
      if (state == ST_WRITEBACK && !wb_kill) begin
        u_hist[chan_p0]  <= data_out;
        e2_hist[chan_p0] <= e1_p0;
        e1_hist[chan_p0] <= e_mac;
      end
      // placed after the writeback so a clear of the same channel wins
      if (clear_in && int'(clear_chan_in) < N_CH) begin
        u_hist[clear_chan_in]  <= '0;
        e1_hist[clear_chan_in] <= '0;
        e2_hist[clear_chan_in] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pid_core_mc.sv
// Bench for pid_core_mc: directed steps followed by randomized traffic, all
// checked against a plain-arithmetic model of each channel's PID loop.
module tb_pid_core_mc;
  localparam int N_CH = 6, W_CH = 3, W_IN = 18, W_OUT = 32, W_EP = 16;
  localparam int LIM_SHIFT = 0, CL = 2;

  logic clk = 1'b0;
  logic reset_n;
  logic signed [W_IN-1:0]  data_in;
  logic [W_CH-1:0]         data_chan_in;
  logic                    data_valid_in, data_ready_out;
  logic                    param_wr_in;
  logic [W_CH-1:0]         param_chan_in;
  logic [2:0]              param_addr_in;
  logic signed [W_EP-1:0]  param_data_in;
  logic                    update_en_in, update_in, clear_in;
  logic [W_CH-1:0]         clear_chan_in;
  logic signed [W_OUT-1:0] data_out;
  logic [W_CH-1:0]         data_chan_out;
  logic                    data_valid_out;

  always #5 clk = ~clk;

  pid_core_mc #(.N_CH(N_CH), .W_CH(W_CH), .W_IN(W_IN), .W_OUT(W_OUT), .W_EP(W_EP),
                .LIM_SHIFT(LIM_SHIFT), .COMP_LATENCY(CL)) dut (
    .clk_in(clk), .reset_n_in(reset_n),
    .data_in(data_in), .data_chan_in(data_chan_in), .data_valid_in(data_valid_in),
    .data_ready_out(data_ready_out),
    .param_wr_in(param_wr_in), .param_chan_in(param_chan_in),
    .param_addr_in(param_addr_in), .param_data_in(param_data_in),
    .update_en_in(update_en_in), .update_in(update_in),
    .clear_in(clear_in), .clear_chan_in(clear_chan_in),
    .data_out(data_out), .data_chan_out(data_chan_out), .data_valid_out(data_valid_out)
  );

  int n_pass = 0, n_total = 0;

  // channel model: shadow (s_*) and active (a_*) params, history
  longint s_sp[N_CH], s_p[N_CH], s_i[N_CH], s_d[N_CH], s_lo[N_CH], s_hi[N_CH];
  longint a_sp[N_CH], a_p[N_CH], a_i[N_CH], a_d[N_CH], a_lo[N_CH], a_hi[N_CH];
  bit     s_pol[N_CH], a_pol[N_CH];
  longint hu[N_CH], he1[N_CH], he2[N_CH];

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic void model_reset();
    for (int c = 0; c < N_CH; c++) begin
      s_sp[c] = 0; s_p[c] = 0; s_i[c] = 0; s_d[c] = 0; s_pol[c] = 0;
      s_lo[c] = -(longint'(1) << (W_OUT - 1));
      s_hi[c] = (longint'(1) << (W_OUT - 1)) - 1;
      a_sp[c] = 0; a_p[c] = 0; a_i[c] = 0; a_d[c] = 0; a_pol[c] = 0;
      a_lo[c] = s_lo[c]; a_hi[c] = s_hi[c];
      hu[c] = 0; he1[c] = 0; he2[c] = 0;
    end
  endfunction

  function automatic void model_commit();
    for (int c = 0; c < N_CH; c++) begin
      a_sp[c] = s_sp[c]; a_p[c] = s_p[c]; a_i[c] = s_i[c]; a_d[c] = s_d[c];
      a_lo[c] = s_lo[c]; a_hi[c] = s_hi[c]; a_pol[c] = s_pol[c];
    end
  endfunction

  // velocity-form PID step straight from the loop equations
  function automatic void model_step(input int ch, input longint dat,
                                     output longint u, output longint e);
    longint s;
    e = a_pol[ch] ? dat - a_sp[ch] : a_sp[ch] - dat;
    s = hu[ch] + (a_p[ch] + a_i[ch] + a_d[ch]) * e
        + (-a_p[ch] - 2 * a_d[ch]) * he1[ch] + a_d[ch] * he2[ch];
    s = (s <<< (64 - (W_OUT + 1))) >>> (64 - (W_OUT + 1));
    if (a_lo[ch] > a_hi[ch]) u = a_hi[ch];
    else if (s > a_hi[ch])   u = a_hi[ch];
    else if (s < a_lo[ch])   u = a_lo[ch];
    else                     u = s;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr_param(input int ch, input int addr, input longint val);
    logic signed [W_EP-1:0] v16;
    longint v;
    v16 = W_EP'(val);
    v = v16;
    param_wr_in = 1'b1; param_chan_in = W_CH'(ch);
    param_addr_in = 3'(addr); param_data_in = v16;
    tick();
    param_wr_in = 1'b0;
    if (ch < N_CH) begin
      case (addr)
        0: s_sp[ch] = v;
        1: s_p[ch]  = v;
        2: s_i[ch]  = v;
        3: s_d[ch]  = v;
        4: s_lo[ch] = v <<< LIM_SHIFT;
        5: s_hi[ch] = v <<< LIM_SHIFT;
        6: s_pol[ch] = v16[0];
        default: ;
      endcase
    end
  endtask

  task automatic do_update(input bit en);
    update_in = 1'b1; update_en_in = en;
    tick();
    update_in = 1'b0; update_en_in = 1'b0;
    if (en) model_commit();
  endtask

  task automatic do_clear(input int ch);
    clear_in = 1'b1; clear_chan_in = W_CH'(ch);
    tick();
    clear_in = 1'b0;
    hu[ch] = 0; he1[ch] = 0; he2[ch] = 0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (data_ready_out !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("ready_wait", data_ready_out, 1);
  endtask

  // One sample through the core. hold keeps offering a bogus sample while busy;
  // clr_mid / upd_mid pulse clear / update during COMPUTE. lit<>NOLIT adds a literal check.
  localparam longint NOLIT = -(longint'(1) <<< 60);
  task automatic sample(input int ch, input longint dat, input bit hold,
                        input bit clr_mid, input bit upd_mid, input longint lit);
    longint exp_u, exp_e;
    int k;
    bit seen;
    wait_ready();
    data_in = W_IN'(dat); data_chan_in = W_CH'(ch); data_valid_in = 1'b1;
    model_step(ch, dat, exp_u, exp_e);
    tick();
    if (hold) data_in = W_IN'(dat + 77);
    else data_valid_in = 1'b0;
    k = 1; seen = 0;
    check("busy_ready", data_ready_out, 0);
    if (clr_mid) begin clear_in = 1'b1; clear_chan_in = W_CH'(ch); end
    if (upd_mid) begin update_in = 1'b1; update_en_in = 1'b1; end
    while (!seen && k < 12) begin
      tick();
      clear_in = 1'b0; update_in = 1'b0; update_en_in = 1'b0;
      k++;
      if (data_valid_out === 1'b1) seen = 1;
    end
    data_valid_in = 1'b0;
    if (upd_mid) model_commit();
    check("strobe_seen", seen, 1);
    check("latency", k, CL + 1);
    check("data_out", data_out, exp_u);
    check("data_chan_out", data_chan_out, ch);
    if (lit != NOLIT) check("data_out_lit", data_out, lit);
    tick();
    check("strobe_width", data_valid_out, 0);
    if (clr_mid) begin
      hu[ch] = 0; he1[ch] = 0; he2[ch] = 0;
    end else begin
      hu[ch] = exp_u; he2[ch] = he1[ch]; he1[ch] = exp_e;
    end
  endtask

  task automatic count_no_strobe(input string tag, input int cycles);
    int strobes = 0;
    for (int n = 0; n < cycles; n++) begin
      tick();
      if (data_valid_out !== 1'b0) strobes++;
    end
    check(tag, strobes, 0);
  endtask

  initial begin
    reset_n = 1'b0; data_in = '0; data_chan_in = '0; data_valid_in = 1'b0;
    param_wr_in = 1'b0; param_chan_in = '0; param_addr_in = '0; param_data_in = '0;
    update_en_in = 1'b0; update_in = 1'b0; clear_in = 1'b0; clear_chan_in = '0;
    model_reset();
    repeat (3) tick();
    check("rst_ready", data_ready_out, 0);
    check("rst_valid", data_valid_out, 0);
    check("rst_data", data_out, 0);
    check("rst_chan", data_chan_out, 0);
    reset_n = 1'b1;
    tick();

    // proportional only
    wr_param(0, 1, 10); wr_param(0, 0, 100); do_update(1);
    sample(0, 0, 0, 0, 0, 1000);

    // integral accumulation, then reversed polarity
    wr_param(2, 2, 3); wr_param(2, 0, 5); do_update(1);
    sample(2, 0, 0, 0, 0, 15); sample(2, 0, 0, 0, 0, 30); sample(2, 0, 0, 0, 0, 45);
    do_clear(2);
    wr_param(2, 6, 3); wr_param(2, 0, 0); do_update(1);
    sample(2, 5, 0, 0, 0, 15); sample(2, 5, 0, 0, 0, 30); sample(2, 5, 0, 0, 0, 45);
    // update without enable must not commit
    wr_param(2, 2, 100); do_update(0);
    sample(2, 5, 0, 0, 0, 60);

    // clamp as anti-windup
    wr_param(1, 5, 100); wr_param(1, 2, 10); wr_param(1, 0, 50); do_update(1);
    sample(1, 0, 0, 0, 0, 100); sample(1, 0, 0, 0, 0, 100);
    wr_param(1, 0, -5); do_update(1);
    sample(1, 0, 0, 0, 0, 50);
    // inverted window resolves to out_max
    wr_param(4, 4, 50); wr_param(4, 5, 10); wr_param(4, 2, 1); do_update(1);
    sample(4, 0, 0, 0, 0, 10);

    // interleaved channels; one sample offered while busy
    wr_param(3, 1, 2); wr_param(3, 2, 1); wr_param(3, 3, 1); wr_param(3, 0, 7);
    // update coincident with a write: the write stays in the shadow
    param_wr_in = 1'b1; param_chan_in = 3'd3; param_addr_in = 3'd1; param_data_in = 16'sd9;
    update_in = 1'b1; update_en_in = 1'b1;
    tick();
    param_wr_in = 1'b0; update_in = 1'b0; update_en_in = 1'b0;
    model_commit(); s_p[3] = 9;
    sample(0, 20, 0, 0, 0, NOLIT); sample(3, 1, 1, 0, 0, NOLIT);
    sample(0, 40, 0, 0, 0, NOLIT); sample(3, 2, 0, 0, 0, NOLIT);
    sample(3, -3, 1, 0, 0, NOLIT); sample(0, -7, 0, 0, 0, NOLIT);

    // clear and update landing mid-compute
    sample(3, 4, 0, 1, 0, NOLIT);
    sample(3, 4, 0, 0, 0, NOLIT);
    wr_param(3, 1, -6);
    sample(3, 1, 0, 0, 1, NOLIT);
    sample(3, 1, 0, 0, 0, NOLIT);

    // reset during COMPUTE aborts the sample
    wait_ready();
    data_in = 18'sd33; data_chan_in = 3'd0; data_valid_in = 1'b1;
    tick();
    data_valid_in = 1'b0;
    reset_n = 1'b0;
    #1;
    check("rst_mid_ready", data_ready_out, 0);
    tick();
    reset_n = 1'b1;
    model_reset();
    check("rst_mid_valid", data_valid_out, 0);
    check("rst_mid_data", data_out, 0);
    check("rst_mid_chan", data_chan_out, 0);
    count_no_strobe("rst_mid_nostrobe", 8);
    wr_param(0, 1, 1); wr_param(0, 3, 1); wr_param(0, 0, 3); do_update(1);
    sample(0, 0, 0, 0, 0, 6);

    // out-of-range channel is taken and dropped
    wait_ready();
    data_in = 18'sd500; data_chan_in = 3'(N_CH); data_valid_in = 1'b1;
    tick();
    data_valid_in = 1'b0;
    count_no_strobe("drop_nostrobe", 8);
    sample(0, 0, 0, 0, 0, NOLIT);

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      int ch;
      logic signed [W_IN-1:0] r;
      if ($urandom_range(0, 2) == 0)
        wr_param($urandom_range(0, N_CH - 1), $urandom_range(0, 7), longint'($urandom));
      if ($urandom_range(0, 3) == 0) do_update(1);
      if ($urandom_range(0, 9) == 0) do_clear($urandom_range(0, N_CH - 1));
      ch = $urandom_range(0, N_CH - 1);
      r = W_IN'($urandom);
      sample(ch, longint'(r), 1'($urandom_range(0, 1)), 0, 0, NOLIT);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
